seq_tx_moore: RTL
=================

Name: seq_tx_moore

Overview:
- Serial pattern transmitter. It is the driving end of the single-bit serial stream consumed by the team's Moore sequence detectors.
- On a start request it captures a parallel pattern and shifts it out MSB-first on d_out, one bit per clock.
- It optionally repeats the pattern with a fixed one-cycle zero gap between frames, then pulses done.
- It is used as a stimulus source and as an on-chip serial sequence generator.

Parameters:
- WIDTH, 8, pattern length in bits (>=2).
- REP_W, 4, width of the repeat-count input.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- start  input  1  transmission request, sampled only in IDLE.
- pattern  input  WIDTH  bits to send, MSB first; captured on accept.
- repeat_cnt  input  REP_W  extra repetitions; frames sent = repeat_cnt+1; captured on accept.
- d_out  output  1  serial bit stream, registered.
- frame  output  1  high while d_out carries a pattern bit, registered.
- busy  output  1  high from accept until return to IDLE (SHIFT/GAP/DONE), registered.
- done  output  1  one-cycle pulse after the last bit of the last frame, registered.

Behaviour:
- Moore FSM with states IDLE, SHIFT, GAP, DONE. All outputs are registers that are functions of state and datapath only; no combinational path from inputs to outputs.
- Reset (reset==0 at a rising edge): state=IDLE; d_out=0, frame=0, busy=0, done=0; shift register, bit counter and repeat counter cleared. Reset overrides everything, including mid-frame; no partial frame resumes.
- IDLE: d_out=0, frame=0, busy=0, done=0.
  - If start==1 at the edge: shreg<=pattern, rep<=repeat_cnt, bitcnt<=WIDTH-1, state<=SHIFT.
  - In the same edge d_out<=pattern[WIDTH-1], frame<=1, busy<=1.
  - Latency: the first bit is valid in the cycle immediately after the accepting edge.
- SHIFT: d_out presents one bit per cycle, MSB to LSB; frame=1, busy=1.
  - If bitcnt!=0, the shift register advances and bitcnt decrements.
  - If bitcnt==0 (LSB on line) and rep!=0: state<=GAP and rep decrements.
  - If bitcnt==0 and rep==0: state<=DONE.
- GAP: exactly one cycle; d_out=0, frame=0, busy=1. The captured pattern copy is reloaded into shreg, bitcnt<=WIDTH-1, state<=SHIFT.
- DONE: exactly one cycle; done=1, busy=1, d_out=0, frame=0, then state<=IDLE.
- Start handling:
  - start is ignored in SHIFT, GAP and DONE.
  - pattern and repeat_cnt changes after accept have no effect (a private copy is held).
  - With start held high continuously, the next frame is accepted on the edge leaving IDLE. The minimum spacing is therefore one IDLE cycle after DONE.
- Timing for R=repeat_cnt: busy cycles = (R+1)*WIDTH + R + 1; frame-high cycles = (R+1)*WIDTH.
- repeat_cnt at its maximum (2^REP_W-1) is legal; the repeat counter must not wrap.
- Unused/illegal state encodings recover to IDLE on the next edge with outputs cleared.

Test Plan:
1. reset=0 for 2 edges with start=1 -> d_out=0, frame=0, busy=0, done=0 throughout; no accept while in reset.
2. pattern=8'hA5, repeat_cnt=0, one-cycle start pulse:
   - d_out=1,0,1,0,0,1,0,1 on 8 consecutive cycles with frame=1.
   - Then one cycle with done=1, busy=1, d_out=0.
   - busy high for exactly 9 cycles.
3. pattern=8'hF0, repeat_cnt=2 -> three frames 11110000 separated by single zero-gap cycles (frame=0); 26 busy cycles before the DONE cycle; done pulses once; busy total 27 cycles.
4. pattern=8'h3C, repeat_cnt=0; change pattern to 8'hFF and pulse start during cycle 4 -> line still shows 00111100; no second frame is started.
5. start held at 1, pattern=8'h81, repeat_cnt=0 -> frames repeat with period 10 cycles (8 bits + DONE + IDLE); the IDLE cycle shows d_out=0, busy=0.
6. repeat_cnt=1, pattern=8'hFF; drive reset=0 during the GAP cycle -> next cycle all outputs are 0 and state is IDLE; a new start yields a fresh full frame.

Source files
------------

// File: rtl/seq_tx_moore.sv
// seq_tx_moore: serial pattern transmitter.
// Captures a parallel pattern on a start request and shifts it out MSB-first,
// optionally repeating it with a one-cycle zero gap between frames, then
// pulses done. All outputs are registers loaded with the Moore output of the
// state being entered, so nothing combinational reaches the pins from inputs.
module seq_tx_moore #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic             d_out,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;   // bits still to go; MSB is on the line
  logic [WIDTH-1:0] pat, pat_n;       // private copy reloaded for each repeat
  logic [CW-1:0]    bitcnt, bitcnt_n; // bits remaining after the one on the line
  logic [REP_W-1:0] rep, rep_n;       // frames remaining after the current one
  logic             d_out_n, frame_n, busy_n, done_n;

  // Next-state, datapath and next-output logic.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    pat_n    = pat;
    bitcnt_n = bitcnt;
    rep_n    = rep;
    d_out_n  = 1'b0;
    frame_n  = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          pat_n    = pattern;
          shreg_n  = pattern;
          rep_n    = repeat_cnt;
          bitcnt_n = CW'(WIDTH - 1);
          state_n  = SHIFT;
          d_out_n  = pattern[WIDTH-1];
          frame_n  = 1'b1;
          busy_n   = 1'b1;
        end
      end

      SHIFT: begin
        if (bitcnt != '0) begin
          shreg_n  = shreg << 1;
          bitcnt_n = bitcnt - CW'(1);
          d_out_n  = shreg[WIDTH-2];
          frame_n  = 1'b1;
          busy_n   = 1'b1;
        end else if (rep != '0) begin
          // Decrement only when non-zero, so the maximum count never wraps.
          rep_n   = rep - REP_W'(1);
          state_n = GAP;
          busy_n  = 1'b1;
        end else begin
          state_n = DONE;
          busy_n  = 1'b1;
          done_n  = 1'b1;
        end
      end

      GAP: begin
        shreg_n  = pat;
        bitcnt_n = CW'(WIDTH - 1);
        state_n  = SHIFT;
        d_out_n  = pat[WIDTH-1];
        frame_n  = 1'b1;
        busy_n   = 1'b1;
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the datapath registers are reset too, so an interrupted frame leaves
  // no stale bits or counts behind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      pat    <= '0;
      bitcnt <= '0;
      rep    <= '0;
      d_out  <= 1'b0;
      frame  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      pat    <= pat_n;
      bitcnt <= bitcnt_n;
      rep    <= rep_n;
      d_out  <= d_out_n;
      frame  <= frame_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule
